// File: rtl/lsu_axi_rd_arb.sv
// lsu_axi_rd_arb: shares the LSU AXI read channel between the IRAM loader
// (requester 0) and the WRAM loader (requester 1).
// - Arbitrates AR requests, registers the winning payload and holds it on AR.
// - Tags arid with {per-owner tag counter, owner} and limits outstanding
//   bursts per owner to MAX_OUT.
// - Routes R beats combinationally back to the owner named in rid[0].
// Build option: define LSU_RD_ARB_FIXED_PRIO_EN to make requester 0 win every
// tie (fixed priority). Left undefined, ties are resolved round-robin.
//
// state | meaning
// IDLE  | no AR in flight; accept the next eligible requester
// ADDR  | registered AR held valid until the master accepts it

module lsu_axi_rd_arb #(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_vld,
  output logic [1:0]  req_rdy,
  input  logic [9:0]  req0_addr,
  input  logic [9:0]  req1_addr,
  input  logic [7:0]  req0_len,
  input  logic [7:0]  req1_len,
  input  logic [2:0]  req0_str,
  input  logic [2:0]  req1_str,
  input  logic [7:0]  req0_num,
  input  logic [7:0]  req1_num,
  output logic [7:0]  lsu_axi_arid,
  output logic [9:0]  lsu_axi_araddr,
  output logic [7:0]  lsu_axi_arlen,
  output logic [2:0]  lsu_axi_arsize,
  output logic [1:0]  lsu_axi_arburst,
  output logic [2:0]  lsu_axi_arstr,
  output logic [7:0]  lsu_axi_arnum,
  output logic        lsu_axi_arvld,
  input  logic        axi_lsu_arrdy,
  input  logic [7:0]  axi_lsu_rid,
  input  logic [63:0] axi_lsu_rdata,
  input  logic [1:0]  axi_lsu_rresp,
  input  logic        axi_lsu_rlast,
  input  logic        axi_lsu_rvld,
  output logic        lsu_axi_rrdy,
  output logic [1:0]  rsp_vld,
  output logic [63:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  input  logic [1:0]  rsp_rdy,
  output logic        busy
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  typedef enum logic {S_IDLE = 1'b0, S_ADDR = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [7:0]      arid_q;
  logic [9:0]      araddr_q;
  logic [7:0]      arlen_q;
  logic [2:0]      arstr_q;
  logic [7:0]      arnum_q;
  logic [1:0][6:0] tag_q;
  logic [1:0][3:0] cnt_q, cnt_d;

  logic [1:0] elig;
  logic       win;
  logic       grant;
  logic       ar_hs;
  logic       r_done;
  logic       r_own;
  logic       unused_rid;

  // rid[7:1] only matters to the owner; the arbiter routes on rid[0] alone
  assign unused_rid = ^axi_lsu_rid[7:1];

  // A requester is eligible while it has room for another outstanding burst
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_vld[i] && (cnt_q[i] < MAX_CNT);
    end
  end

`ifdef LSU_RD_ARB_FIXED_PRIO_EN
  // Fixed priority: the IRAM loader wins whenever it is eligible
  always_comb begin
    win = !elig[0];
  end
`else
  logic last_gnt_q;

  // Round-robin: on a tie the requester not granted last time wins
  always_comb begin
    win = (elig == 2'b11) ? !last_gnt_q : elig[1];
  end

  // Remember the most recent winner; reset value lets req0 win the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
    end else if (grant) begin
      last_gnt_q <= win;
    end
  end
`endif

  assign grant  = (state_q == S_IDLE) && (elig != 2'b00);
  assign ar_hs  = (state_q == S_ADDR) && axi_lsu_arrdy;
  assign r_own  = axi_lsu_rid[0];
  assign r_done = axi_lsu_rvld && lsu_axi_rrdy && axi_lsu_rlast;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ADDR;
      S_ADDR:  if (axi_lsu_arrdy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; req_rdy is forced low while reset is asserted so a waiting
  // requester never sees an acceptance that the arbiter does not record
  always_comb begin
    req_rdy       = 2'b00;
    lsu_axi_arvld = 1'b0;
    case (state_q)
      S_IDLE:  if (grant && rst_n) req_rdy = win ? 2'b10 : 2'b01;
      S_ADDR:  lsu_axi_arvld = 1'b1;
      default: ;
    endcase
  end

  // Capture the winner's payload and tag it; the tag advances per grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arid_q   <= 8'h00;
      araddr_q <= 10'h000;
      arlen_q  <= 8'h00;
      arstr_q  <= 3'h0;
      arnum_q  <= 8'h00;
      tag_q    <= '0;
    end else if (grant) begin
      arid_q     <= {tag_q[win], win};
      araddr_q   <= win ? req1_addr : req0_addr;
      arlen_q    <= win ? req1_len  : req0_len;
      arstr_q    <= win ? req1_str  : req0_str;
      arnum_q    <= win ? req1_num  : req0_num;
      tag_q[win] <= tag_q[win] + 7'd1;
    end
  end

  // Outstanding-burst bookkeeping; an AR issue and a final beat for the same
  // owner in one cycle cancel, and a stray final beat never underflows
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (ar_hs && (arid_q[0] == 1'(i)) && !(r_done && (r_own == 1'(i)))) begin
        if (cnt_q[i] < MAX_CNT) cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (r_done && (r_own == 1'(i)) && !(ar_hs && (arid_q[0] == 1'(i)))) begin
        if (cnt_q[i] != 4'd0) cnt_d[i] = cnt_q[i] - 4'd1;
      end
    end
  end

  // Outstanding counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lsu_axi_arid    = arid_q;
  assign lsu_axi_araddr  = araddr_q;
  assign lsu_axi_arlen   = arlen_q;
  assign lsu_axi_arsize  = 3'd3;
  assign lsu_axi_arburst = 2'b01;
  assign lsu_axi_arstr   = arstr_q;
  assign lsu_axi_arnum   = arnum_q;

  assign lsu_axi_rrdy = rsp_rdy[r_own];
  assign rsp_vld      = {axi_lsu_rvld && r_own, axi_lsu_rvld && !r_own};
  assign rsp_data     = axi_lsu_rdata;
  assign rsp_last     = axi_lsu_rlast;
  assign rsp_err      = (axi_lsu_rresp != 2'b00);

  assign busy = (state_q == S_ADDR) || (cnt_q[0] != 4'd0) || (cnt_q[1] != 4'd0);

endmodule

// File: tb/tb_lsu_axi_rd_arb.sv
module tb_lsu_axi_rd_arb;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_vld, req_rdy;
  logic [9:0]  req0_addr, req1_addr;
  logic [7:0]  req0_len, req1_len;
  logic [2:0]  req0_str, req1_str;
  logic [7:0]  req0_num, req1_num;
  logic [7:0]  arid;
  logic [9:0]  araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [2:0]  arstr;
  logic [7:0]  arnum;
  logic        arvld, arrdy;
  logic [7:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvld, rrdy;
  logic [1:0]  rsp_vld;
  logic [63:0] rsp_data;
  logic        rsp_last, rsp_err;
  logic [1:0]  rsp_rdy;
  logic        busy;

  lsu_axi_rd_arb #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_len(req0_len), .req1_len(req1_len),
    .req0_str(req0_str), .req1_str(req1_str),
    .req0_num(req0_num), .req1_num(req1_num),
    .lsu_axi_arid(arid), .lsu_axi_araddr(araddr), .lsu_axi_arlen(arlen),
    .lsu_axi_arsize(arsize), .lsu_axi_arburst(arburst), .lsu_axi_arstr(arstr),
    .lsu_axi_arnum(arnum), .lsu_axi_arvld(arvld), .axi_lsu_arrdy(arrdy),
    .axi_lsu_rid(rid), .axi_lsu_rdata(rdata), .axi_lsu_rresp(rresp),
    .axi_lsu_rlast(rlast), .axi_lsu_rvld(rvld), .lsu_axi_rrdy(rrdy),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .rsp_rdy(rsp_rdy), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the arbiter
  typedef struct {
    logic [7:0] id;
    logic [9:0] addr;
    logic [7:0] len;
    logic [2:0] str;
    logic [7:0] num;
  } ar_t;

  ar_t ar_q[$];
  bit  m_pend;
  int  m_cnt[2];
  int  m_tag[2];
  int  m_last;
  int  n_grants = 0;

  task automatic model_reset();
    m_pend = 0;
    m_cnt  = '{0, 0};
    m_tag  = '{0, 0};
    m_last = 1;
    ar_q.delete();
  endtask

  // Monitor/scoreboard: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_rdy", {62'd0, req_rdy}, 64'd0);
      chk("rst_arvld", {63'd0, arvld}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_arid", {56'd0, arid}, 64'd0);
      chk("rst_araddr", {54'd0, araddr}, 64'd0);
      model_reset();
    end else begin
      int  own;
      bit  e0, e1, r_done, ar_done;
      int  w, ar_own;
      logic [1:0] exp_rdy;
      ar_t a;

      own = int'(rid[0]);
      chk("rsp_vld", {62'd0, rsp_vld}, rvld ? (own == 1 ? 64'd2 : 64'd1) : 64'd0);
      chk("rrdy", {63'd0, rrdy}, {63'd0, rsp_rdy[own]});
      chk("rsp_err", {63'd0, rsp_err}, (rresp != 2'b00) ? 64'd1 : 64'd0);
      if (rvld) begin
        chk("rsp_data", rsp_data, rdata);
        chk("rsp_last", {63'd0, rsp_last}, {63'd0, rlast});
      end
      chk("busy", {63'd0, busy}, (m_pend || m_cnt[0] != 0 || m_cnt[1] != 0) ? 64'd1 : 64'd0);
      chk("arvld", {63'd0, arvld}, {63'd0, m_pend});

      // expected arbitration decision
      e0 = req_vld[0] && (m_cnt[0] < MAX_OUT);
      e1 = req_vld[1] && (m_cnt[1] < MAX_OUT);
      exp_rdy = 2'b00;
      if (!m_pend && (e0 || e1)) begin
        if (e0 && e1) begin
`ifdef LSU_RD_ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = 1 - m_last;
`endif
        end else begin
          w = e1 ? 1 : 0;
        end
        exp_rdy  = (w == 1) ? 2'b10 : 2'b01;
        a.id   = 8'((m_tag[w] << 1) | w);
        a.addr = (w == 1) ? req1_addr : req0_addr;
        a.len  = (w == 1) ? req1_len  : req0_len;
        a.str  = (w == 1) ? req1_str  : req0_str;
        a.num  = (w == 1) ? req1_num  : req0_num;
        ar_q.push_back(a);
        m_tag[w] = (m_tag[w] + 1) % 128;
        m_last   = w;
        n_grants++;
      end
      chk("req_rdy", {62'd0, req_rdy}, {62'd0, exp_rdy});

      // AR channel must present the queued burst, stable until accepted
      ar_done = 0;
      ar_own  = 0;
      if (m_pend) begin
        if (ar_q.size() == 0) begin
          chk("ar_queue_nonempty", 64'd0, 64'd1);
        end else begin
          a = ar_q[0];
          chk("arid", {56'd0, arid}, {56'd0, a.id});
          chk("araddr", {54'd0, araddr}, {54'd0, a.addr});
          chk("arlen", {56'd0, arlen}, {56'd0, a.len});
          chk("arstr", {61'd0, arstr}, {61'd0, a.str});
          chk("arnum", {56'd0, arnum}, {56'd0, a.num});
          chk("arsize", {61'd0, arsize}, 64'd3);
          chk("arburst", {62'd0, arburst}, 64'd1);
          if (arrdy) begin
            ar_done = 1;
            ar_own  = int'(a.id[0]);
            void'(ar_q.pop_front());
          end
        end
      end

      r_done = rvld && rsp_rdy[own] && rlast;
      for (int k = 0; k < 2; k++) begin
        bit inc, dec;
        inc = ar_done && ar_own == k;
        dec = r_done && own == k;
        if (inc && !dec) m_cnt[k] = m_cnt[k] + 1;
        else if (dec && !inc && m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
      end

      if (ar_done) m_pend = 0;
      if (exp_rdy != 2'b00) m_pend = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    req0_addr = 10'($urandom);
    req1_addr = 10'($urandom);
    req0_len  = 8'($urandom);
    req1_len  = 8'($urandom);
    req0_str  = 3'($urandom);
    req1_str  = 3'($urandom);
    req0_num  = 8'($urandom);
    req1_num  = 8'($urandom);
  endtask

  // percentages: request valid, AR ready, R valid, rlast
  task automatic drive_random(input int p_req, input int p_ar, input int p_rv, input int p_last);
    rand_payload();
    req_vld[0] = ($urandom_range(99) < p_req);
    req_vld[1] = ($urandom_range(99) < p_req);
    arrdy      = ($urandom_range(99) < p_ar);
    rvld       = ($urandom_range(99) < p_rv);
    rlast      = ($urandom_range(99) < p_last);
    rid        = 8'($urandom);
    rdata      = {$urandom, $urandom};
    rresp      = 2'($urandom);
    rsp_rdy    = 2'($urandom);
  endtask

  task automatic idle_r();
    rvld = 0; rlast = 0; rid = 8'h00; rresp = 2'b00; rsp_rdy = 2'b00;
  endtask

  initial begin
    rst_n = 0;
    req_vld = 2'b00; arrdy = 0;
    rdata = 64'd0;
    rand_payload();
    idle_r();
    model_reset();
    repeat (3) step();
    rst_n = 1;

    // both requesting, AR always ready: alternating grants from req0
    req_vld = 2'b11; arrdy = 1;
    repeat (8) begin rand_payload(); step(); end

    // AR stalled: payload and arid must hold, no new acceptance
    arrdy = 0;
    repeat (6) begin rand_payload(); step(); end
    arrdy = 1;

    // only req0 and no R return: fills its outstanding limit
    req_vld = 2'b01;
    repeat (14) begin rand_payload(); step(); end
    // req1 must still be served while req0 is blocked
    req_vld = 2'b11;
    repeat (6) begin rand_payload(); step(); end

    // final beat for owner 1 routed and counted
    req_vld = 2'b00;
    rvld = 1; rid = 8'h03; rsp_rdy = 2'b10; rlast = 1; rresp = 2'b00;
    step();
    rresp = 2'b10; rid = 8'h00; rsp_rdy = 2'b01;
    step();
    idle_r();
    step();

    // randomized traffic with phases of heavy issue and heavy return
    for (int ph = 0; ph < 12; ph++) begin
      int p_rv;
      p_rv = (ph % 3 == 0) ? 5 : (ph % 3 == 1) ? 60 : 30;
      repeat (400) begin
        drive_random(80, 60, p_rv, 50);
        step();
      end
      if (ph == 5) begin
        // reset while traffic is in flight
        req_vld = 2'b11; arrdy = 0; idle_r();
        step();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
      end
    end

    idle_r();
    req_vld = 2'b00;
    step();
    rst_n = 0;
    step();
    step();

    chk("grants_seen", {63'd0, (n_grants > 300)}, 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
